dec_dly_comp_path_trunc: RTL and testbench
==========================================

# dec_dly_comp_path_trunc

Streaming, parametrised successor to the compile-time path-sanitising helper used by the dec_dly_comp simulation flow. It accepts a character string as multi-lane beats, stores up to MAX_CHARS characters and emits a fixed-length, zero-padded record. The record holds either the prefix before the first delimiter or the basename after the last delimiter. It sits between the host-side string/config feed and any consumer that needs a bounded, delimiter-free name field.

## Interface
- CHAR_W, 8: bits per character.
- LANES, 4: characters per beat; lane 0 (bits [CHAR_W-1:0]) is the earliest character.
- MAX_CHARS, 16: record length in characters; must be a multiple of LANES.
- DELIM, 8'h2F: delimiter character ("/").
- MODE, 0: 0 = keep prefix before first DELIM; 1 = keep suffix after last DELIM.
- clk  in  1  single clock, all state on rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- in_data  in  LANES*CHAR_W  input characters.
- in_cnt  in  $clog2(LANES+1)  valid lanes (1..LANES), low lanes first; meaningful only with in_last; non-last beats carry LANES.
- in_valid / in_ready  in / out  1  input handshake.
- in_last  in  1  final beat of string.
- out_data  out  LANES*CHAR_W  record beat; 0 when out_valid=0.
- out_valid / out_ready  out / in  1  output handshake.
- out_last  out  1  final record beat.
- out_len  out  $clog2(MAX_CHARS+1)  kept character count, stable for whole record.
- out_ovf  out  1  input exceeded MAX_CHARS, stable for whole record.

## Operation
- FSM states: FILL and DRAIN; reset state is FILL.
- in_ready = (state==FILL). out_valid = (state==DRAIN).
- FILL, per accepted beat:
  - Write lanes to buffer at wr_ptr and advance wr_ptr by valid lanes.
  - Characters at index ≥ MAX_CHARS are dropped; len saturates at MAX_CHARS; ovf sets.
  - Delimiter tracking covers stored characters only, scanning lanes in ascending order within a beat.
  - fpos = index of first DELIM (init MAX_CHARS).
  - lpos = index of last DELIM (init "none").
- Accepted in_last → DRAIN next cycle; beat index b=0.
- DRAIN, output char at record position p = b*LANES + lane:
  - MODE0: buf[p] if p < min(fpos,len), else 0.
  - MODE1: with s = (lpos none ? 0 : lpos+1), output buf[s+p] if s+p < len, else 0 (unaligned per-lane mux).
- out_len: MODE0 = min(fpos,len); MODE1 = len−s.
- Accepted beat advances b. out_last = (b == MAX_CHARS/LANES−1).
- Accepted last beat → FILL next cycle; all tracking state cleared.
- Empty input (in_last with in_cnt... treated as ≥1) is not supported.

## Timing
- Reset (async assert, sync release): state FILL, out_valid 0, out_data 0, out_last 0, out_len 0, out_ovf 0, in_ready 1 after release.
- First out beat valid the cycle after in_last is accepted.
- Full record takes MAX_CHARS/LANES cycles with out_ready held high.
- Each out beat (data, last, len, ovf) is held stable while out_valid && !out_ready.
- in_ready is 0 for the whole of DRAIN; there is no overlap between strings.
- Delimiter handling:
  - DELIM at index 0, MODE0: out_len 0, all-zero record.
  - Trailing DELIM, MODE1: out_len 0.
  - Multiple DELIMs in one beat resolve by lane order.
- Reset mid-FILL or mid-DRAIN discards the string immediately; no partial record is emitted.

## Test plan
- MODE0, LANES4, MAX16: "ab/c","def" (in_cnt 3, last) → beats "ab\0\0", then 3 zero beats; out_len 2, ovf 0, out_last on beat 3.
- MODE1, same input → "cdef", then 3 zero beats; out_len 4.
- No delimiter, "abcdefg", both modes → "abcd","efg\0", 2 zero beats; out_len 7.
- Overflow, 20 chars with '/' at index 18, MODE0 → first 16 chars, out_len 16, ovf 1.
- Edge delimiters:
  - "/abc" MODE0 → 4 zero beats, out_len 0.
  - "abc/" MODE1 → 4 zero beats, out_len 0.
  - "a//b" MODE1 → "b", out_len 1.
- Backpressure and reset:
  - Random out_ready: beats stay stable while stalled; in_ready stays 0 until the out_last handshake.
  - areset_n pulsed after one FILL beat: outputs 0 while asserted.
  - After release, "x/y" MODE0 → "x", out_len 1.

Source files
------------

// File: rtl/dec_dly_comp_path_trunc.sv
// Streaming path sanitiser: collects a string in multi-lane beats and emits a
// fixed-length, zero-padded record holding the prefix or basename around DELIM.
module dec_dly_comp_path_trunc #(
  parameter int               CHAR_W    = 8,
  parameter int               LANES     = 4,
  parameter int               MAX_CHARS = 16,
  parameter logic [CHAR_W-1:0] DELIM    = 8'h2F,
  parameter int               MODE      = 0
) (
  input  logic                             clk,
  input  logic                             areset_n,
  input  logic [LANES*CHAR_W-1:0]          in_data,
  input  logic [$clog2(LANES+1)-1:0]       in_cnt,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  output logic [LANES*CHAR_W-1:0]          out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic [$clog2(MAX_CHARS+1)-1:0]   out_len,
  output logic                             out_ovf,
  output logic [0:0]                       o_dbg_state
);

  localparam int CW = $clog2(LANES+1);
  localparam int LW = $clog2(MAX_CHARS+1);
  localparam int IW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int XW = LW + 1;
  localparam int NB = MAX_CHARS / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [LW-1:0] MAXL  = LW'(MAX_CHARS);
  localparam logic [BW-1:0] LASTB = BW'(NB - 1);

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  // Handshake: a beat transfers on a rising edge where valid && ready; the
  // sender holds its beat stable until then, and ready never depends on valid.
  logic [0:0]        r_state;
  logic [CHAR_W-1:0] r_buf [MAX_CHARS];
  logic [LW-1:0]     r_len;
  logic [LW-1:0]     r_fpos;
  logic [LW-1:0]     r_lpos;
  logic              r_lvld;
  logic              r_ovf;
  logic [BW-1:0]     r_b;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [CW-1:0]     w_cnt;
  logic [LW-1:0]     w_len_n;
  logic [LW-1:0]     w_fpos_n;
  logic [LW-1:0]     w_lpos_n;
  logic              w_lvld_n;
  logic              w_ovf_n;
  logic [LANES-1:0]  w_we;
  logic [IW-1:0]     w_waddr [LANES];
  logic [LW-1:0]     w_keep0;
  logic [LW-1:0]     w_s;
  logic [LW-1:0]     w_olen;

  assign w_in_fire  = in_valid && (r_state == S_FILL);
  assign w_out_fire = out_ready && (r_state == S_DRAIN);

  // The running length doubles as the write pointer: stored characters are
  // contiguous, and anything past MAX_CHARS only raises the overflow flag.
  always_comb begin
    w_len_n  = r_len;
    w_fpos_n = r_fpos;
    w_lpos_n = r_lpos;
    w_lvld_n = r_lvld;
    w_ovf_n  = r_ovf;
    w_cnt    = in_last ? in_cnt : CW'(LANES);
    for (int l = 0; l < LANES; l++) begin
      w_we[l]    = 1'b0;
      w_waddr[l] = '0;
      if (w_in_fire && (l < int'(w_cnt))) begin
        if (w_len_n < MAXL) begin
          w_we[l]    = 1'b1;
          w_waddr[l] = w_len_n[IW-1:0];
          if (in_data[l*CHAR_W +: CHAR_W] == DELIM) begin
            if (w_fpos_n == MAXL) w_fpos_n = w_len_n;
            w_lpos_n = w_len_n;
            w_lvld_n = 1'b1;
          end
          w_len_n = w_len_n + LW'(1);
        end else begin
          w_ovf_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_we[l]) r_buf[w_waddr[l]] <= in_data[l*CHAR_W +: CHAR_W];
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= S_FILL;
      r_len   <= '0;
      r_fpos  <= MAXL;
      r_lpos  <= '0;
      r_lvld  <= 1'b0;
      r_ovf   <= 1'b0;
      r_b     <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          r_len  <= w_len_n;
          r_fpos <= w_fpos_n;
          r_lpos <= w_lpos_n;
          r_lvld <= w_lvld_n;
          r_ovf  <= w_ovf_n;
          if (w_in_fire && in_last) begin
            r_state <= S_DRAIN;
            r_b     <= '0;
          end
        end
        default: begin
          if (w_out_fire) begin
            if (r_b == LASTB) begin
              r_state <= S_FILL;
              r_len   <= '0;
              r_fpos  <= MAXL;
              r_lpos  <= '0;
              r_lvld  <= 1'b0;
              r_ovf   <= 1'b0;
              r_b     <= '0;
            end else begin
              r_b <= r_b + BW'(1);
            end
          end
        end
      endcase
    end
  end

  assign w_keep0 = (r_fpos < r_len) ? r_fpos : r_len;
  assign w_s     = r_lvld ? (r_lpos + LW'(1)) : '0;
  assign w_olen  = (MODE == 0) ? w_keep0 : (r_len - w_s);

  // Basename mode reads from an unaligned start, so each lane has its own mux.
  always_comb begin
    logic [XW-1:0] v_p;
    logic [XW-1:0] v_src;
    logic [XW-1:0] v_lim;
    out_data = '0;
    for (int l = 0; l < LANES; l++) begin
      v_p = XW'(r_b) * XW'(LANES) + XW'(l);
      if (MODE == 0) begin
        v_src = v_p;
        v_lim = XW'(w_keep0);
      end else begin
        v_src = XW'(w_s) + v_p;
        v_lim = XW'(r_len);
      end
      if ((r_state == S_DRAIN) && (v_src < v_lim))
        out_data[l*CHAR_W +: CHAR_W] = r_buf[v_src[IW-1:0]];
    end
  end

  assign in_ready    = (r_state == S_FILL);
  assign out_valid   = (r_state == S_DRAIN);
  assign out_last    = (r_state == S_DRAIN) && (r_b == LASTB);
  assign out_len     = (r_state == S_DRAIN) ? w_olen : '0;
  assign out_ovf     = (r_state == S_DRAIN) && r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dec_dly_comp_path_trunc.sv
// Bench for dec_dly_comp_path_trunc: one instance per MODE share the input
// stream and out_ready; records are predicted from the string itself.
module tb_dec_dly_comp_path_trunc;

  localparam int CHAR_W = 8;
  localparam int LANES  = 4;
  localparam int MAXC   = 16;
  localparam int NB     = MAXC / LANES;
  localparam int W      = LANES * CHAR_W;
  localparam int CW     = $clog2(LANES+1);
  localparam int LW     = $clog2(MAXC+1);

  logic          clk;
  logic          areset_n;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_cnt;
  logic          in_valid;
  logic          in_last;
  logic          out_ready;

  logic          in_ready_0, in_ready_1;
  logic [W-1:0]  out_data_0, out_data_1;
  logic          out_valid_0, out_valid_1;
  logic          out_last_0, out_last_1;
  logic [LW-1:0] out_len_0, out_len_1;
  logic          out_ovf_0, out_ovf_1;
  logic [0:0]    dbg_0, dbg_1;

  dec_dly_comp_path_trunc #(.CHAR_W(CHAR_W), .LANES(LANES), .MAX_CHARS(MAXC), .DELIM(8'h2F), .MODE(0)) u_m0 (
    .clk(clk), .areset_n(areset_n), .in_data(in_data), .in_cnt(in_cnt), .in_valid(in_valid),
    .in_ready(in_ready_0), .in_last(in_last), .out_data(out_data_0), .out_valid(out_valid_0),
    .out_ready(out_ready), .out_last(out_last_0), .out_len(out_len_0), .out_ovf(out_ovf_0),
    .o_dbg_state(dbg_0));

  dec_dly_comp_path_trunc #(.CHAR_W(CHAR_W), .LANES(LANES), .MAX_CHARS(MAXC), .DELIM(8'h2F), .MODE(1)) u_m1 (
    .clk(clk), .areset_n(areset_n), .in_data(in_data), .in_cnt(in_cnt), .in_valid(in_valid),
    .in_ready(in_ready_1), .in_last(in_last), .out_data(out_data_1), .out_valid(out_valid_1),
    .out_ready(out_ready), .out_last(out_last_1), .out_len(out_len_1), .out_ovf(out_ovf_1),
    .o_dbg_state(dbg_1));

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  byte unsigned str_q[$];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           exp_len0, exp_len1;
  logic         exp_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    str_q = {};
    for (int i = 0; i < s.len(); i++) str_q.push_back(s[i]);
  endtask

  // Reference: keep at most MAXC characters, then cut around the first or
  // last '/' among the kept ones and left-justify into a zero-filled record.
  task automatic model();
    byte unsigned st[$];
    byte unsigned rec[MAXC];
    int s, e;
    logic [W-1:0] w;
    exp_q0 = {};
    exp_q1 = {};
    st = {};
    for (int i = 0; i < str_q.size() && i < MAXC; i++) st.push_back(str_q[i]);
    exp_ovf = (str_q.size() > MAXC);
    for (int m = 0; m < 2; m++) begin
      s = 0;
      e = st.size();
      if (m == 0) begin
        for (int i = st.size() - 1; i >= 0; i--) if (st[i] == 8'h2F) e = i;
      end else begin
        for (int i = 0; i < st.size(); i++) if (st[i] == 8'h2F) s = i + 1;
      end
      for (int i = 0; i < MAXC; i++) rec[i] = 8'h00;
      for (int i = s; i < e; i++) rec[i-s] = st[i];
      if (m == 0) exp_len0 = e - s; else exp_len1 = e - s;
      for (int b = 0; b < NB; b++) begin
        w = '0;
        for (int l = 0; l < LANES; l++) w[l*CHAR_W +: CHAR_W] = rec[b*LANES+l];
        if (m == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
      end
    end
  endtask

  // driver: entered and left at posedge+1
  task automatic send();
    int n  = str_q.size();
    int nb = (n + LANES - 1) / LANES;
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      in_cnt   = in_last ? CW'(n - b*LANES) : CW'(LANES);
      for (int l = 0; l < LANES; l++)
        in_data[l*CHAR_W +: CHAR_W] = (b*LANES + l < n) ? str_q[b*LANES+l] : 8'($urandom);
      @(negedge clk);
      check("in_ready_fill_m0", in_ready_0, 1);
      check("in_ready_fill_m1", in_ready_1, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int beat = 0;
    int cyc  = 0;
    bit fire;
    while (beat < NB && cyc < 200) begin
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      check("out_valid_m0", out_valid_0, 1);
      check("out_valid_m1", out_valid_1, 1);
      check("in_ready_drain", {in_ready_0, in_ready_1}, 2'b00);
      check("dbg_state_drain", {dbg_0, dbg_1}, 2'b11);
      check("data_m0", out_data_0, exp_q0[0]);
      check("data_m1", out_data_1, exp_q1[0]);
      check("last_m0", out_last_0, (beat == NB - 1));
      check("last_m1", out_last_1, (beat == NB - 1));
      check("len_m0", out_len_0, exp_len0);
      check("len_m1", out_len_1, exp_len1);
      check("ovf_m0", out_ovf_0, exp_ovf);
      check("ovf_m1", out_ovf_1, exp_ovf);
      fire = out_ready;
      @(posedge clk); #1;
      if (fire) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
        beat++;
      end
      cyc++;
    end
    if (beat < NB) check("drain_timeout", beat, NB);
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_valid", {out_valid_0, out_valid_1}, 2'b00);
    check("idle_ready", {in_ready_0, in_ready_1}, 2'b11);
    check("idle_data", {out_data_0, out_data_1}, 64'h0);
    @(posedge clk); #1;
  endtask

  task automatic run_str(input string s, input bit rnd);
    load_str(s);
    model();
    send();
    drain(rnd);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {out_valid_0, out_valid_1}, 2'b00);
    check({tag, "_data"}, {out_data_0, out_data_1}, 64'h0);
    check({tag, "_last"}, {out_last_0, out_last_1}, 2'b00);
    check({tag, "_len"}, {out_len_0, out_len_1}, 10'h0);
    check({tag, "_ovf"}, {out_ovf_0, out_ovf_1}, 2'b00);
    check({tag, "_state"}, {dbg_0, dbg_1}, 2'b00);
  endtask

  initial begin
    string s;
    areset_n  = 1'b0;
    in_data   = '0;
    in_cnt    = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    areset_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", {in_ready_0, in_ready_1}, 2'b11);
    check_zero("after_release");
    @(posedge clk); #1;

    run_str("ab/cdef", 1'b0);
    run_str("abcdefg", 1'b0);
    run_str("abcdefghijklmnopqr/t", 1'b0);
    run_str("/abc", 1'b0);
    run_str("abc/", 1'b0);
    run_str("a//b", 1'b0);
    run_str("abcdefghijklmnop", 1'b1);
    run_str("abcdefghijklmno/", 1'b1);

    // reset during FILL after one beat
    in_valid = 1'b1; in_last = 1'b0; in_cnt = CW'(LANES); in_data = 32'h632F6261;
    @(posedge clk); #1;
    in_valid = 1'b0;
    areset_n = 1'b0;
    #1;
    check_zero("rst_fill");
    @(posedge clk); #1;
    check_zero("rst_fill_hold");
    areset_n = 1'b1;
    @(posedge clk); #1;
    run_str("x/y", 1'b0);

    // reset during DRAIN discards the record
    load_str("qq/rr");
    model();
    send();
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {out_valid_0, out_valid_1}, 2'b11);
    areset_n = 1'b0;
    #1;
    check_zero("rst_drain");
    @(posedge clk); #1;
    areset_n = 1'b1;
    @(negedge clk);
    check_zero("rst_drain_after");
    check("rst_drain_ready", {in_ready_0, in_ready_1}, 2'b11);
    @(posedge clk); #1;

    for (int t = 0; t < 25; t++) begin
      s = "";
      for (int i = 0; i < int'($urandom_range(1, 22)); i++)
        s = {s, ($urandom_range(0, 4) == 0) ? "/" : string'(8'($urandom_range(97, 122)))};
      run_str(s, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
